fetch_queue_path: RTL and testbench

//  Next-generation fetch stage for the pipelined core. Owns the PC and fetches

---
 rtl/fetch_queue_path.sv | 109 ++++++++++
 tb/tb_fetch_queue_path.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_path.sv
// Fetch stage: owns the PC, fetches over an imem req/ack handshake and buffers
// fetched words in a small FIFO so decode stalls do not stall fetch.
module fetch_queue_path #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_data_i,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] pc_br_d_i,
    input  logic [XLEN-1:0] pc_jmp_d_i,
    input  logic            pc_src_d_i,
    input  logic            jmp_i,
    input  logic            take_f_i,
    output logic            valid_f_o,
    output logic [XLEN-1:0] inst_f_o,
    output logic [XLEN-1:0] pc_plus4_f_o
);

    localparam int unsigned PtrW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CntW = $clog2(QDEPTH + 1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [XLEN-1:0] inst_mem_q [QDEPTH];
    logic [XLEN-1:0] pc4_mem_q  [QDEPTH];

    logic            redirect;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] target_raw;
    logic [XLEN-1:0] pc_plus4;
    logic            full;
    logic            push;
    logic            pop;

    always_comb begin
        redirect   = jmp_i | pc_src_d_i;
        target_raw = jmp_i ? pc_jmp_d_i : pc_br_d_i;
        target     = {target_raw[XLEN-1:2], 2'b00};
        pc_plus4   = fetch_pc_q + XLEN'(4);
        full       = (count_q == CntW'(QDEPTH));

        // Request is independent of ack, so an ack while full or redirecting is dropped.
        imem_req_o  = !reset_i && !full && !redirect;
        imem_addr_o = fetch_pc_q;
        push        = imem_req_o && imem_ack_i;

        valid_f_o    = !reset_i && (count_q != '0);
        pop          = take_f_i && valid_f_o && !redirect;
        inst_f_o     = valid_f_o ? inst_mem_q[head_q] : '0;
        pc_plus4_f_o = valid_f_o ? pc4_mem_q[head_q]  : '0;
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (redirect) begin
            fetch_pc_d = target;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                tail_d     = tail_q + PtrW'(1);
                fetch_pc_d = pc_plus4;
            end
            if (pop) begin
                head_d = head_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            inst_mem_q[tail_q] <= imem_data_i;
            pc4_mem_q[tail_q]  <= pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_queue_path.sv
// Scoreboard bench for fetch_queue_path: a producer models accepted fetches,
// a negedge monitor compares the queue head and fetch request against the model.
module tb_fetch_queue_path;

    localparam logic [31:0] K = 32'h5A5A_0F0F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req;
    logic [31:0] addr;
    logic [31:0] data;
    logic        ack = 1'b0;
    logic [31:0] br = '0;
    logic [31:0] jt = '0;
    logic        src = 1'b0;
    logic        jmp = 1'b0;
    logic        take = 1'b0;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc4;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_pc = '0;
    logic        exp_req_q = 1'b0;
    logic        ev;
    logic        er;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Instruction memory: word content is a fixed function of the address.
    assign data = addr ^ K;

    fetch_queue_path #(
        .XLEN    (32),
        .QDEPTH  (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk_i       (clk),
        .reset_i     (rst),
        .imem_req_o  (req),
        .imem_addr_o (addr),
        .imem_data_i (data),
        .imem_ack_i  (ack),
        .pc_br_d_i   (br),
        .pc_jmp_d_i  (jt),
        .pc_src_d_i  (src),
        .jmp_i       (jmp),
        .take_f_i    (take),
        .valid_f_o   (valid),
        .inst_f_o    (inst),
        .pc_plus4_f_o(pc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Producer: mirrors what the DUT should do at each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            exp_pc <= '0;
        end else if (jmp || src) begin
            sb.delete();
            exp_pc <= (jmp ? jt : br) & 32'hFFFF_FFFC;
        end else if (exp_req_q && ack) begin
            sb.push_back({exp_pc ^ K, exp_pc + 32'd4});
            exp_pc <= exp_pc + 32'd4;
        end
    end

    // Monitor: compare mid-cycle, then retire the head if decode takes it.
    always @(negedge clk) begin
        ev = !rst && (sb.size() != 0);
        er = !rst && !(jmp || src) && (sb.size() < 4);
        chk("valid_F", {31'b0, valid}, {31'b0, ev});
        if (ev) begin
            chk("inst_F", inst, sb[0].inst);
            chk("pc_plus4_F", pc4, sb[0].pc4);
        end else begin
            chk("inst_F_zero", inst, 32'h0);
            chk("pc_plus4_F_zero", pc4, 32'h0);
        end
        chk("imem_req", {31'b0, req}, {31'b0, er});
        if (er) chk("imem_addr", addr, exp_pc);
        exp_req_q <= er;
        if (ev && take && !(jmp || src)) void'(sb.pop_front());
    end

    task automatic step(input logic r, input logic j, input logic s, input logic [31:0] b,
                        input logic [31:0] t, input logic tk, input logic ak);
        @(posedge clk);
        #1;
        rst  = r;
        jmp  = j;
        src  = s;
        br   = b;
        jt   = t;
        take = tk;
        ack  = ak;
    endtask

    task automatic run(input int n, input logic tk, input logic ak);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, tk, ak);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        // Streaming: ack and take every cycle.
        do_reset();
        run(8, 1'b1, 1'b1);

        // Fill to capacity with acks still asserted, then free one slot.
        do_reset();
        run(7, 1'b0, 1'b1);
        run(1, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1);
        run(6, 1'b1, 1'b0);

        // Slow memory: ack every third cycle.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, (i % 3) == 2);
        end

        // Branch with three words queued and an ack in the redirect cycle.
        do_reset();
        run(3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0);
        run(4, 1'b1, 1'b1);

        // Jump and branch together: jump wins, low bits cleared.
        step(1'b0, 1'b1, 1'b1, 32'h500, 32'h203, 1'b1, 1'b1);
        run(4, 1'b1, 1'b1);

        // Reset while a request is pending, ack during reset.
        do_reset();
        run(2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        run(3, 1'b1, 1'b1);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b1, 1'b1);
        run(4, 1'b1, 1'b1);
        run(2, 1'b1, 1'b0);

        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
